// File: rtl/mem_burst_pkg.sv
// Shared types and default geometry for the mem_burst_ctrl slice.
package mem_burst_pkg;

  localparam int unsigned DefAw    = 10;
  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefLw    = 4;
  localparam int unsigned DefRdLat = 1;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StDrain
  } state_e;

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Shift register of {valid,last} read tags that tracks reads in flight to the memory.
module mem_rd_tag_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_valid_i,
  input  logic push_last_i,
  output logic empty_o,
  output logic tail_valid_o,
  output logic tail_last_o
);

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] last_q, last_d;

  always_comb begin
    valid_d = {valid_q[Depth-2:0], push_valid_i};
    last_d  = {last_q[Depth-2:0], push_valid_i & push_last_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign empty_o      = ~|valid_q;
  assign tail_valid_o = valid_q[Depth-1];
  assign tail_last_o  = last_q[Depth-1];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst request controller for a single-port synchronous memory.
// Define MEM_BURST_BOUNDS_EN to drop (and flag via err_o) bursts that would cross the top address.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int unsigned AW     = DefAw,
  parameter int unsigned DW     = DefDw,
  parameter int unsigned LW     = DefLw,
  parameter int unsigned RD_LAT = DefRdLat
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_wr_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic          wd_valid_i,
  output logic          wd_ready_o,
  input  logic [DW-1:0] wd_data_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_data_o,
  output logic          rsp_last_o,
  output logic          busy_o,
  output logic          err_o,
  output logic          mem_en_o,
  output logic          mem_wr_rd_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wr_data_o,
  input  logic [DW-1:0] mem_rd_data_i
);

  localparam int unsigned CW = LW + 1;

  state_e        state_q, state_d;
  logic          started_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_wr_rd_q, mem_wr_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wr_data_q, mem_wr_data_d;
  logic          rsp_valid_q, rsp_last_q;
  logic [DW-1:0] rsp_data_q;
  logic          err_q, err_d;
  logic          cmd_hs, wd_hs, oob;
  logic          tag_push, tag_push_last, tag_empty, tail_valid, tail_last;

  // started_q keeps cmd_ready low while reset is held.
  assign cmd_ready_o = started_q && (state_q == StIdle);
  assign wd_ready_o  = (state_q == StWr);
  assign busy_o      = (state_q != StIdle);
  assign cmd_hs      = cmd_valid_i & cmd_ready_o;
  assign wd_hs       = wd_valid_i & wd_ready_o;

`ifdef MEM_BURST_BOUNDS_EN
  logic [AW:0] end_addr;
  assign end_addr = {1'b0, cmd_addr_i} + (AW+1)'(cmd_len_i);
  assign oob      = end_addr[AW];
`else
  assign oob = 1'b0;
`endif

  assign err_d = cmd_hs & oob;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    mem_en_d      = 1'b0;
    mem_wr_rd_d   = mem_wr_rd_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    tag_push      = 1'b0;
    tag_push_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_hs && !oob) begin
          addr_d  = cmd_addr_i;
          cnt_d   = CW'(cmd_len_i) + CW'(1);
          state_d = cmd_wr_i ? StWr : StRd;
        end
      end
      StWr: begin
        if (wd_hs) begin
          mem_en_d      = 1'b1;
          mem_wr_rd_d   = 1'b1;
          mem_addr_d    = addr_q;
          mem_wr_data_d = wd_data_i;
          addr_d        = addr_q + AW'(1);
          cnt_d         = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = StIdle;
        end
      end
      StRd: begin
        mem_en_d      = 1'b1;
        mem_wr_rd_d   = 1'b0;
        mem_addr_d    = addr_q;
        addr_d        = addr_q + AW'(1);
        cnt_d         = cnt_q - CW'(1);
        tag_push      = 1'b1;
        tag_push_last = (cnt_q == CW'(1));
        if (cnt_q == CW'(1)) state_d = StDrain;
      end
      StDrain: begin
        if (tag_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      started_q     <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      mem_en_q      <= 1'b0;
      mem_wr_rd_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      started_q     <= 1'b1;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      mem_en_q      <= mem_en_d;
      mem_wr_rd_q   <= mem_wr_rd_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      err_q         <= err_d;
    end
  end

  // Tag enters one cycle before mem_en is visible, so the tail lines up with valid rd_data.
  mem_rd_tag_pipe #(
    .Depth(RD_LAT + 1)
  ) u_tag_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_valid_i(tag_push),
    .push_last_i (tag_push_last),
    .empty_o     (tag_empty),
    .tail_valid_o(tail_valid),
    .tail_last_o (tail_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= tail_valid;
      rsp_last_q  <= tail_valid & tail_last;
      if (tail_valid) rsp_data_q <= mem_rd_data_i;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_last_o    = rsp_last_q;
  assign rsp_data_o    = rsp_data_q;
  assign err_o         = err_q;
  assign mem_en_o      = mem_en_q;
  assign mem_wr_rd_o   = mem_wr_rd_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed self-checking bench for mem_burst_ctrl with a behavioural 1Kx8 memory attached.
module tb_mem_burst_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rsp_valid, rsp_last, busy, err;
  logic [DW-1:0] rsp_data;
  logic          mem_en, mem_wr_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;

  always #5 clk = ~clk;

  mem_burst_ctrl #(
    .AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_wr_i     (cmd_wr),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .wd_valid_i   (wd_valid),
    .wd_ready_o   (wd_ready),
    .wd_data_i    (wd_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_last_o   (rsp_last),
    .busy_o       (busy),
    .err_o        (err),
    .mem_en_o     (mem_en),
    .mem_wr_rd_o  (mem_wr_rd),
    .mem_addr_o   (mem_addr),
    .mem_wr_data_o(mem_wr_data),
    .mem_rd_data_i(mem_rd_data)
  );

  // Single-port synchronous memory, read latency 1.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_rd) mem[mem_addr] <= mem_wr_data;
      else           mem_rd_data   <= mem[mem_addr];
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  logic        log_en  = 1'b0;

  int unsigned   iss_cyc[$];
  logic [AW-1:0] iss_addr[$];
  logic          iss_wr[$];
  logic [DW-1:0] iss_data[$];
  int unsigned   rsp_cyc[$];
  logic [DW-1:0] rsp_dat[$];
  logic          rsp_lst[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (log_en) begin
      if (mem_en) begin
        iss_cyc.push_back(cyc);
        iss_addr.push_back(mem_addr);
        iss_wr.push_back(mem_wr_rd);
        iss_data.push_back(mem_wr_data);
      end
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc);
        rsp_dat.push_back(rsp_data);
        rsp_lst.push_back(rsp_last);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    iss_cyc.delete(); iss_addr.delete(); iss_wr.delete(); iss_data.delete();
    rsp_cyc.delete(); rsp_dat.delete(); rsp_lst.delete();
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int unsigned k = 0;
    while (!cmd_ready && k < 50) begin
      tick();
      k++;
    end
    check("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input int n, input logic [DW-1:0] base);
    wd_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wd_data = base + DW'(i);
      tick();
    end
    wd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    check("idle_timeout", {31'b0, busy}, 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_write_log(input logic [AW-1:0] base, input int n, input logic [DW-1:0] d0);
    logic [AW-1:0] a;
    check("wr_beats", iss_cyc.size(), n);
    for (int i = 0; i < n && i < iss_cyc.size(); i++) begin
      a = base + AW'(i);
      check($sformatf("wr_addr%0d", i), iss_addr[i], a);
      check($sformatf("wr_dir%0d", i), iss_wr[i], 1);
      check($sformatf("wr_data%0d", i), iss_data[i], d0 + DW'(i));
      check($sformatf("wr_cyc%0d", i), iss_cyc[i], iss_cyc[0] + i);
    end
  endtask

  task automatic check_read_log(input logic [AW-1:0] base, input int n, input logic [DW-1:0] d0);
    logic [AW-1:0] a;
    check("rd_issues", iss_cyc.size(), n);
    for (int i = 0; i < n && i < iss_cyc.size(); i++) begin
      a = base + AW'(i);
      check($sformatf("rd_addr%0d", i), iss_addr[i], a);
      check($sformatf("rd_dir%0d", i), iss_wr[i], 0);
      check($sformatf("rd_iss_cyc%0d", i), iss_cyc[i], iss_cyc[0] + i);
    end
    check("rsp_beats", rsp_cyc.size(), n);
    if (rsp_cyc.size() > 0 && iss_cyc.size() > 0)
      check("rsp_latency", rsp_cyc[0], iss_cyc[0] + RD_LAT + 1);
    for (int i = 0; i < n && i < rsp_cyc.size(); i++) begin
      check($sformatf("rsp_data%0d", i), rsp_dat[i], d0 + DW'(i));
      check($sformatf("rsp_last%0d", i), rsp_lst[i], (i == n - 1) ? 1 : 0);
      check($sformatf("rsp_cyc%0d", i), rsp_cyc[i], rsp_cyc[0] + i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0;
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wd_ready", wd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_last", rsp_last, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wr_rd", mem_wr_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wr_data", mem_wr_data, 0);
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    log_en = 1'b1;

    // Back-to-back write burst.
    clear_log();
    send_cmd(1'b1, 10'h010, 4'd3);
    check("wr_busy", busy, 1);
    check("wr_wd_ready", wd_ready, 1);
    check("wr_cmd_ready", cmd_ready, 0);
    write_beats(4, 8'hA0);
    wait_idle();
    check_write_log(10'h010, 4, 8'hA0);

    // Read it back.
    clear_log();
    send_cmd(1'b0, 10'h010, 4'd3);
    wait_idle();
    check_read_log(10'h010, 4, 8'hA0);

    // Burst crossing the top address.
    clear_log();
    send_cmd(1'b1, 10'h3FE, 4'd3);
`ifdef MEM_BURST_BOUNDS_EN
    check("oob_err_pulse", err, 1);
    check("oob_stay_idle", busy, 0);
    tick();
    check("oob_err_once", err, 0);
    wait_idle();
    check("oob_no_mem", iss_cyc.size(), 0);
`else
    check("wrap_no_err", err, 0);
    write_beats(4, 8'hC0);
    wait_idle();
    check_write_log(10'h3FE, 4, 8'hC0);
    clear_log();
    send_cmd(1'b0, 10'h3FE, 4'd3);
    wait_idle();
    check_read_log(10'h3FE, 4, 8'hC0);
`endif

    // Gapped write data with a command held pending.
    clear_log();
    send_cmd(1'b1, 10'h020, 4'd1);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h100; cmd_len = 4'd0;
    wd_valid = 1'b1; wd_data = 8'hB0;
    tick();
    check("gap_en0", mem_en, 1);
    check("gap_addr0", mem_addr, 10'h020);
    check("gap_data0", mem_wr_data, 8'hB0);
    check("gap_cmd_stall0", cmd_ready, 0);
    wd_valid = 1'b0; wd_data = 8'h55;
    tick();
    check("gap_en1", mem_en, 0);
    check("gap_data_hold", mem_wr_data, 8'hB0);
    check("gap_cmd_stall1", cmd_ready, 0);
    wd_valid = 1'b1; wd_data = 8'hB1;
    tick();
    check("gap_en2", mem_en, 1);
    check("gap_addr2", mem_addr, 10'h021);
    check("gap_data2", mem_wr_data, 8'hB1);
    cmd_valid = 1'b0; wd_valid = 1'b1; wd_data = 8'hEE;
    tick();
    check("idle_wd_ignored", mem_en, 0);
    check("idle_wd_ready", wd_ready, 0);
    check("idle_busy", busy, 0);
    wd_valid = 1'b0;
    tick();

    // Reset after two beats of an 8-beat read.
    clear_log();
    send_cmd(1'b0, 10'h010, 4'd7);
    tick();
    check("mid_iss0", mem_addr, 10'h010);
    tick();
    check("mid_iss1", mem_addr, 10'h011);
    clear_log();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_en", mem_en, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (8) tick();
    check("mid_no_rsp", rsp_cyc.size(), 0);
    check("mid_no_issue", iss_cyc.size(), 0);
    clear_log();
    send_cmd(1'b0, 10'h010, 4'd3);
    wait_idle();
    check_read_log(10'h010, 4, 8'hA0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
